// File: rtl/drf_pkg.sv
// Shared definitions for the DRF datapath sequencer: opcodes, ALU operation
// codes, flag bit positions, sequencer states and the decoded-instruction
// record passed from cu_decoder to control_unit.
package drf_pkg;

  // 5-bit opcodes (IR[15:11])
  localparam logic [4:0] OpNop  = 5'h00;
  localparam logic [4:0] OpAdd  = 5'h01;
  localparam logic [4:0] OpSub  = 5'h02;
  localparam logic [4:0] OpAnd  = 5'h03;
  localparam logic [4:0] OpOr   = 5'h04;
  localparam logic [4:0] OpXor  = 5'h05;
  localparam logic [4:0] OpCmp  = 5'h06;
  localparam logic [4:0] OpMov  = 5'h07;
  localparam logic [4:0] OpLdi  = 5'h08;
  localparam logic [4:0] OpLd   = 5'h09;
  localparam logic [4:0] OpSt   = 5'h0A;
  localparam logic [4:0] OpSetb = 5'h0B;
  localparam logic [4:0] OpJmp  = 5'h10;
  localparam logic [4:0] OpJz   = 5'h11;
  localparam logic [4:0] OpJnz  = 5'h12;
  localparam logic [4:0] OpJc   = 5'h13;
  localparam logic [4:0] OpJn   = 5'h14;
  localparam logic [4:0] OpHalt = 5'h1F;

  // ALU operation codes
  localparam logic [2:0] AluAdd   = 3'd0;
  localparam logic [2:0] AluSub   = 3'd1;
  localparam logic [2:0] AluAnd   = 3'd2;
  localparam logic [2:0] AluOr    = 3'd3;
  localparam logic [2:0] AluXor   = 3'd4;
  localparam logic [2:0] AluPassB = 3'd5;
  localparam logic [2:0] AluPassA = 3'd6;

  // Flag bit positions
  localparam int unsigned FlagZ = 0;
  localparam int unsigned FlagN = 1;
  localparam int unsigned FlagC = 2;
  localparam int unsigned FlagV = 3;

  typedef enum logic [2:0] {
    StFetch,
    StLoadIr,
    StDecode,
    StExec,
    StMem,
    StHalt
  } cu_state_e;

  typedef enum logic [2:0] {
    CondNone,
    CondAlways,
    CondZ,
    CondNz,
    CondC,
    CondN
  } jump_cond_e;

  typedef struct packed {
    logic       alu;      // two-operand ALU op with write-back
    logic       cmp;
    logic       mov;
    logic       ldi;
    logic       mem_ld;
    logic       mem_st;
    logic       setb;
    jump_cond_e cond;     // CondNone for non-jumps
    logic       halt;
    logic       illegal;
    logic [2:0] alu_op;
  } cu_dec_t;

  function automatic logic cond_met(jump_cond_e cond, logic [3:0] flags);
    logic met;
    met = 1'b0;
    case (cond)
      CondAlways: met = 1'b1;
      CondZ:      met = flags[FlagZ];
      CondNz:     met = ~flags[FlagZ];
      CondC:      met = flags[FlagC];
      CondN:      met = flags[FlagN];
      default:    met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode decoder for the DRF sequencer.
// Ports:
//   opcode_i  5-bit opcode field from IR[15:11]
//   dec_o     decoded instruction class, jump condition and ALU operation
module cu_decoder
  import drf_pkg::*;
(
  input  logic [4:0] opcode_i,
  output cu_dec_t    dec_o
);

  always_comb begin
    dec_o      = '0;
    dec_o.cond = CondNone;
    unique case (opcode_i)
      OpNop:  ;
      OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
        dec_o.alu    = 1'b1;
        // ADD..XOR are laid out so that opcode-1 is the ALU code
        dec_o.alu_op = opcode_i[2:0] - 3'd1;
      end
      OpCmp: begin
        dec_o.cmp    = 1'b1;
        dec_o.alu_op = AluSub;
      end
      OpMov: begin
        dec_o.mov    = 1'b1;
        dec_o.alu_op = AluPassB;
      end
      OpLdi:  dec_o.ldi = 1'b1;
      OpLd: begin
        dec_o.mem_ld = 1'b1;
        dec_o.alu_op = AluPassB;
      end
      OpSt: begin
        dec_o.mem_st = 1'b1;
        dec_o.alu_op = AluPassB;
      end
      OpSetb: dec_o.setb = 1'b1;
      OpJmp:  dec_o.cond = CondAlways;
      OpJz:   dec_o.cond = CondZ;
      OpJnz:  dec_o.cond = CondNz;
      OpJc:   dec_o.cond = CondC;
      OpJn:   dec_o.cond = CondN;
      OpHalt: dec_o.halt = 1'b1;
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the 8-bit DRF datapath. Steps through
// fetch / load-IR / decode / execute (/ memory) and drives every strobe of
// PC, IR, ALU, register bank, bank selector and data memory. Stops in HALT
// until reset.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   in_IR                    current IR word
//   in_ALU_flags             combinational ALU flags {V,C,N,Z}
//   out_PC_*                 program counter load / increment / address drive
//   out_IR_*                 IR capture / immediate drive
//   out_ALU_*                ALU operation and bus drive
//   out_REG_*                register selects and write enable
//   out_MBS_wr_enable        bank selector latch
//   out_MAR_load             data-memory address latch
//   out_data_memory_*        data memory bus drive / write
//   out_halted, out_illegal  status
module control_unit
  import drf_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_IR,
  input  logic [3:0]  in_ALU_flags,
  output logic        out_PC_load,
  output logic        out_PC_inc,
  output logic        out_PC_enOut,
  output logic        out_IR_load,
  output logic        out_IR_enOut,
  output logic [2:0]  out_ALU_op,
  output logic        out_ALU_enable_out,
  output logic [2:0]  out_REG_rx_selector,
  output logic [2:0]  out_REG_ry_selector,
  output logic        out_REG_write_en,
  output logic        out_MBS_wr_enable,
  output logic        out_MAR_load,
  output logic        out_data_memory_enOut,
  output logic        out_data_memory_wr_enable,
  output logic        out_halted,
  output logic        out_illegal
);

  cu_state_e state_q, state_d;
  logic [3:0] flags_q;
  cu_dec_t    dec;

  // Low IR bits are consumed by the datapath directly (imm, address, bank).
  logic unused_ir;
  assign unused_ir = ^in_IR[4:0];

  cu_decoder u_decoder (
    .opcode_i (in_IR[15:11]),
    .dec_o    (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      flags_q <= 4'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StExec && (dec.alu || dec.cmp)) begin
        flags_q <= in_ALU_flags;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  state_d = StLoadIr;
      StLoadIr: state_d = StDecode;
      StDecode: state_d = StExec;
      StExec: begin
        if (dec.mem_ld || dec.mem_st) state_d = StMem;
        else if (dec.halt)            state_d = StHalt;
        else                          state_d = StFetch;
      end
      StMem:    state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    out_PC_load               = 1'b0;
    out_PC_inc                = 1'b0;
    out_PC_enOut              = 1'b0;
    out_IR_load               = 1'b0;
    out_IR_enOut              = 1'b0;
    out_ALU_op                = 3'd0;
    out_ALU_enable_out        = 1'b0;
    out_REG_rx_selector       = 3'd0;
    out_REG_ry_selector       = 3'd0;
    out_REG_write_en          = 1'b0;
    out_MBS_wr_enable         = 1'b0;
    out_MAR_load              = 1'b0;
    out_data_memory_enOut     = 1'b0;
    out_data_memory_wr_enable = 1'b0;
    out_halted                = 1'b0;
    out_illegal               = 1'b0;
    // Reset masks every strobe, including writes in EXEC/MEM.
    if (!rst) begin
      unique case (state_q)
        StFetch:  out_PC_enOut = 1'b1;
        StLoadIr: begin
          out_IR_load = 1'b1;
          out_PC_inc  = 1'b1;
        end
        StDecode: ;
        StExec: begin
          out_REG_rx_selector = in_IR[10:8];
          out_REG_ry_selector = in_IR[7:5];
          out_ALU_op          = dec.alu_op;
          out_ALU_enable_out  = dec.alu || dec.mov || dec.mem_ld || dec.mem_st;
          out_REG_write_en    = dec.alu || dec.mov || dec.ldi;
          out_IR_enOut        = dec.ldi;
          out_MAR_load        = dec.mem_ld || dec.mem_st;
          out_MBS_wr_enable   = dec.setb;
          out_PC_load         = cond_met(dec.cond, flags_q);
          out_illegal         = dec.illegal;
        end
        StMem: begin
          out_REG_rx_selector = in_IR[10:8];
          out_REG_ry_selector = in_IR[7:5];
          if (dec.mem_ld) begin
            out_data_memory_enOut = 1'b1;
            out_REG_write_en      = 1'b1;
          end else if (dec.mem_st) begin
            out_ALU_op                = AluPassA;
            out_ALU_enable_out        = 1'b1;
            out_data_memory_wr_enable = 1'b1;
          end
        end
        StHalt:   out_halted = 1'b1;
        default:  ;
      endcase
    end
  end

endmodule
